// File: rtl/memory_stage_pkg.sv
// Shared encodings for the load/store path: funct3 access sizes, writeback
// select values and the memory-stage FSM states.
package memory_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_NSA  = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // Size comes from funct3[1:0]; 2'b10 and 2'b11 are both word accesses.
    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return ~lo[0];
            default: return (lo == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_load_extend.sv
// Picks the addressed byte/halfword out of a read word and sign- or
// zero-extends it according to funct3.
module load_extend
    import memory_stage_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [31:0] lane;

    always_comb begin
        lane = rdata_i >> {addr_lo_i, 3'b000};
        case (funct3_i)
            F3_B:    data_o = {{24{lane[7]}}, lane[7:0]};
            F3_BU:   data_o = {24'h0, lane[7:0]};
            F3_H:    data_o = {{16{lane[15]}}, lane[15:0]};
            F3_HU:   data_o = {16'h0, lane[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: issues one data-memory request per load/store, stalls
// upstream until the ack, and feeds the MEM/WB register.
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_in,
    input  logic        store_in,
    input  logic        reg_write_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] opb_data_in,
    input  logic [1:0]  mem_reg_in,
    input  logic [31:0] next_sel_addr_in,
    input  logic [31:0] instruction_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wmask,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        misaligned_out,
    output logic        reg_write_out,
    output logic [31:0] wb_data_out,
    output logic [4:0]  rd_out,
    output logic [31:0] instruction_out
);

    mem_state_e  state_q, state_d;
    logic        issue, misaligned_d, memop, aligned;
    logic [2:0]  funct3;
    logic [3:0]  wmask_d;
    logic [31:0] wdata_d, wb_data_d, load_data;

    logic        dmem_we_q, misaligned_q, reg_write_q;
    logic [3:0]  dmem_wmask_q;
    logic [31:0] dmem_addr_q, dmem_wdata_q, wb_data_q, instruction_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [4:0]  rd_q;

    assign funct3  = instruction_in[14:12];
    assign memop   = load_in | store_in;
    assign aligned = is_aligned(funct3, alu_res_in[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        stall_out    = 1'b0;
        issue        = 1'b0;
        misaligned_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (memop && aligned) begin
                    state_d   = WAIT;
                    stall_out = 1'b1;
                    issue     = 1'b1;
                end else if (memop) begin
                    misaligned_d = 1'b1;
                end
            end
            WAIT: begin
                if (dmem_ack) state_d   = IDLE;
                else          stall_out = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Store lanes: narrow data is replicated so the mask alone picks the byte.
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                wmask_d = 4'b0001 << alu_res_in[1:0];
                wdata_d = {4{opb_data_in[7:0]}};
            end
            2'b01: begin
                wmask_d = 4'b0011 << alu_res_in[1:0];
                wdata_d = {2{opb_data_in[15:0]}};
            end
            default: begin
                wmask_d = 4'b1111;
                wdata_d = opb_data_in;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_we_q    <= 1'b0;
            dmem_wmask_q <= 4'b0;
            dmem_addr_q  <= 32'h0;
            dmem_wdata_q <= 32'h0;
            funct3_q     <= 3'b0;
            addr_lo_q    <= 2'b0;
        end else if (issue) begin
            dmem_we_q    <= store_in;
            dmem_wmask_q <= wmask_d;
            dmem_addr_q  <= {alu_res_in[31:2], 2'b00};
            dmem_wdata_q <= wdata_d;
            funct3_q     <= funct3;
            addr_lo_q    <= alu_res_in[1:0];
        end
    end

    load_extend u_load_extend (
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_lo_q),
        .rdata_i   (dmem_rdata),
        .data_o    (load_data)
    );

    always_comb begin
        case (mem_reg_in)
            WB_SEL_LOAD: wb_data_d = load_data;
            WB_SEL_NSA:  wb_data_d = next_sel_addr_in;
            default:     wb_data_d = alu_res_in;
        endcase
    end

    // MEM/WB register: stalled cycles insert a bubble and hold the payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misaligned_q  <= 1'b0;
            reg_write_q   <= 1'b0;
            wb_data_q     <= 32'h0;
            rd_q          <= 5'h0;
            instruction_q <= 32'h0;
        end else begin
            misaligned_q <= misaligned_d;
            if (!stall_out) begin
                reg_write_q   <= reg_write_in & ~store_in & ~misaligned_d;
                wb_data_q     <= wb_data_d;
                rd_q          <= instruction_in[11:7];
                instruction_q <= instruction_in;
            end else begin
                reg_write_q <= 1'b0;
            end
        end
    end

    assign dmem_req        = (state_q == WAIT);
    assign dmem_we         = dmem_we_q;
    assign dmem_wmask      = dmem_wmask_q;
    assign dmem_addr       = dmem_addr_q;
    assign dmem_wdata      = dmem_wdata_q;
    assign misaligned_out  = misaligned_q;
    assign reg_write_out   = reg_write_q;
    assign wb_data_out     = wb_data_q;
    assign rd_out          = rd_q;
    assign instruction_out = instruction_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus randomized ops against a
// transaction-level reference model with a variable-latency memory responder.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_in, store_in, reg_write_in;
    logic [31:0] alu_res_in, opb_data_in, next_sel_addr_in, instruction_in;
    logic [1:0]  mem_reg_in;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wmask;
    logic        stall_out, misaligned_out, reg_write_out;
    logic [31:0] wb_data_out, instruction_out;
    logic [4:0]  rd_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .rst(rst),
        .load_in(load_in), .store_in(store_in), .reg_write_in(reg_write_in),
        .alu_res_in(alu_res_in), .opb_data_in(opb_data_in), .mem_reg_in(mem_reg_in),
        .next_sel_addr_in(next_sel_addr_in), .instruction_in(instruction_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_out(stall_out), .misaligned_out(misaligned_out),
        .reg_write_out(reg_write_out), .wb_data_out(wb_data_out),
        .rd_out(rd_out), .instruction_out(instruction_out)
    );

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_aligned(input logic [2:0] f3, input logic [31:0] a);
        return (a % size_of(f3)) == 0;
    endfunction

    function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [31:0] a);
        int m;
        m = ((1 << size_of(f3)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        int sz;
        sz = size_of(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        longint v, span;
        int sz;
        sz   = size_of(f3);
        span = longint'(1) << (8 * sz);
        v    = (longint'(rd) >> (8 * (a % 4))) % span;
        if (sz < 4 && !f3[2] && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    task automatic drive_nop();
        load_in = 0; store_in = 0; reg_write_in = 0;
        alu_res_in = 0; opb_data_in = 0; mem_reg_in = 0;
        next_sel_addr_in = 0; instruction_in = 32'h13; dmem_ack = 0;
    endtask

    // One EX/MEM op held until the stage stops stalling; lat = WAIT cycles before ack.
    task automatic do_op(input bit ld, input bit st, input bit rw, input logic [31:0] alu,
                         input logic [31:0] opb, input logic [1:0] mr, input logic [31:0] nsa,
                         input logic [31:0] instr, input int lat, input logic [31:0] rdata,
                         input string nm);
        logic [2:0]  f3;
        bit          memop, al, done, exp_mis, exp_rw;
        int          waits, stalls, exp_stalls;
        logic [31:0] exp_wb;
        f3         = instr[14:12];
        memop      = ld | st;
        al         = model_aligned(f3, alu);
        exp_mis    = memop && !al;
        exp_stalls = (memop && al) ? lat + 1 : 0;
        exp_rw     = rw && !st && !exp_mis;
        exp_wb     = (mr == 2'd1) ? model_load(f3, alu, rdata) : (mr == 2'd2) ? nsa : alu;
        load_in = ld; store_in = st; reg_write_in = rw; alu_res_in = alu;
        opb_data_in = opb; mem_reg_in = mr; next_sel_addr_in = nsa; instruction_in = instr;
        waits = 0; stalls = 0; done = 0;
        for (int c = 0; c < lat + 8 && !done; c++) begin
            if (dmem_req) begin
                waits++;
                dmem_ack   = (waits == lat + 1);
                dmem_rdata = dmem_ack ? rdata : $urandom;
            end else begin
                dmem_ack   = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end
            @(negedge clk);
            if (stall_out) stalls++;
            if (dmem_req) begin
                tests++;
                if (!(memop && al) || dmem_addr !== {alu[31:2], 2'b00} || dmem_we !== st) begin
                    fails++;
                    $display("FAIL %s req: addr=%h we=%b required addr=%h we=%b legal=%b",
                             nm, dmem_addr, dmem_we, {alu[31:2], 2'b00}, st, memop && al);
                end
                if (st) begin
                    tests++;
                    if (dmem_wmask !== model_mask(f3, alu) || dmem_wdata !== model_wdata(f3, opb)) begin
                        fails++;
                        $display("FAIL %s store lanes: mask=%b wdata=%h required mask=%b wdata=%h",
                                 nm, dmem_wmask, dmem_wdata, model_mask(f3, alu), model_wdata(f3, opb));
                    end
                end
            end
            done = !stall_out;
            @(posedge clk); #1;
            if (!done) begin
                tests++;
                if (reg_write_out !== 1'b0) begin
                    fails++;
                    $display("FAIL %s bubble: reg_write_out=%b required 0", nm, reg_write_out);
                end
            end
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s timeout: stall_out still %b after budget, required 0", nm, stall_out);
        end
        tests++;
        if (stalls !== exp_stalls) begin
            fails++;
            $display("FAIL %s stall count: %0d required %0d", nm, stalls, exp_stalls);
        end
        tests++;
        if (reg_write_out !== exp_rw || misaligned_out !== exp_mis) begin
            fails++;
            $display("FAIL %s wb ctl: reg_write=%b misaligned=%b required %b %b",
                     nm, reg_write_out, misaligned_out, exp_rw, exp_mis);
        end
        tests++;
        if (rd_out !== instr[11:7] || instruction_out !== instr || dmem_req !== 1'b0) begin
            fails++;
            $display("FAIL %s wb fields: rd=%0d instr=%h req=%b required %0d %h 0",
                     nm, rd_out, instruction_out, dmem_req, instr[11:7], instr);
        end
        if (exp_rw) begin
            tests++;
            if (wb_data_out !== exp_wb) begin
                fails++;
                $display("FAIL %s wb_data: %h required %h", nm, wb_data_out, exp_wb);
            end
        end
        drive_nop();
        @(posedge clk); #1;
        tests++;
        if (misaligned_out !== 1'b0) begin
            fails++;
            $display("FAIL %s misaligned pulse width: misaligned_out=%b required 0", nm, misaligned_out);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd);
        logic [31:0] i;
        i = $urandom;
        i[14:12] = f3;
        i[11:7]  = rd;
        return i;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_nop(); dmem_rdata = 0; rst = 1;
        repeat (2) @(posedge clk); #1;
        tests++;
        if (dmem_req !== 0 || dmem_we !== 0 || dmem_wmask !== 0 || dmem_addr !== 0 ||
            dmem_wdata !== 0 || misaligned_out !== 0 || reg_write_out !== 0 ||
            wb_data_out !== 0 || rd_out !== 0 || instruction_out !== 0) begin
            fails++;
            $display("FAIL reset state: req=%b we=%b mask=%b addr=%h wd=%h mis=%b rw=%b wb=%h rd=%0d ins=%h required all 0",
                     dmem_req, dmem_we, dmem_wmask, dmem_addr, dmem_wdata, misaligned_out,
                     reg_write_out, wb_data_out, rd_out, instruction_out);
        end
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_op(0, 0, 1, 32'h1234, 32'h0, 2'd0, 32'h0, mk_instr(3'b000, 5'd3), 0, 0, "alu");
        do_op(1, 0, 1, 32'h103, 32'h0, 2'd1, 32'h0, mk_instr(3'b000, 5'd4), 3, 32'h80FF_FFFF, "lb_lat3");
        do_op(0, 1, 1, 32'h202, 32'h0000_ABCD, 2'd0, 32'h0, mk_instr(3'b001, 5'd5), 1, 0, "sh");
        do_op(1, 0, 1, 32'h101, 32'h0, 2'd1, 32'h0, mk_instr(3'b010, 5'd6), 0, 0, "lw_misaligned");
        do_op(0, 0, 1, 32'h0, 32'h0, 2'd2, 32'h44, mk_instr(3'b000, 5'd1), 0, 0, "jal");
        do_op(1, 0, 1, 32'h302, 32'h0, 2'd1, 32'h0, mk_instr(3'b101, 5'd7), 0, 32'h9ABC_1234, "lhu");
        do_op(1, 0, 1, 32'h304, 32'h0, 2'd1, 32'h0, mk_instr(3'b111, 5'd8), 2, 32'hCAFE_F00D, "f3_7_as_lw");
        do_op(0, 1, 0, 32'h401, 32'h0, 2'd0, 32'h0, mk_instr(3'b001, 5'd9), 0, 0, "sh_misaligned");
    endtask

    task automatic test_reset_mid_wait();
        load_in = 1; reg_write_in = 1; mem_reg_in = 2'd1; alu_res_in = 32'h200;
        instruction_in = mk_instr(3'b010, 5'd10); dmem_ack = 0;
        @(posedge clk); #1;
        tests++;
        if (dmem_req !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_wait setup: dmem_req=%b required 1", dmem_req);
        end
        rst = 1; #1;
        tests++;
        if (dmem_req !== 1'b0 || reg_write_out !== 1'b0 || stall_out !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_wait async: req=%b rw=%b stall=%b required 0 0 1 (idle, memop held)",
                     dmem_req, reg_write_out, stall_out);
        end
        drive_nop();
        @(posedge clk); #1;
        rst = 0; dmem_ack = 1; dmem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        tests++;
        if (dmem_req !== 1'b0 || stall_out !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_wait late ack: req=%b stall=%b required 0 0", dmem_req, stall_out);
        end
        @(posedge clk); #1;
        dmem_ack = 0;
        tests++;
        if (reg_write_out !== 1'b0 || dmem_req !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_wait writeback: rw=%b req=%b required 0 0", reg_write_out, dmem_req);
        end
    endtask

    task automatic test_random();
        logic [2:0] f3;
        int kind;
        logic [31:0] a;
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 3);
            a    = $urandom;
            if ($urandom_range(0, 1)) a[1:0] = 2'b00;
            case (kind)
                0: do_op(0, 0, 1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3) & 2'b10 | 2'b01 & 2'($urandom_range(0, 1) * 0)),
                         $urandom, mk_instr(3'($urandom), 5'($urandom)), 0, 0, "rnd_alu");
                1: begin
                    f3 = 3'($urandom);
                    do_op(1, 0, 1'($urandom_range(0, 1)), a, $urandom, 2'd1, $urandom,
                          mk_instr(f3, 5'($urandom)), $urandom_range(0, 4), $urandom, "rnd_load");
                end
                2: begin
                    f3 = 3'($urandom_range(0, 2));
                    do_op(0, 1, 1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)), $urandom,
                          mk_instr(f3, 5'($urandom)), $urandom_range(0, 4), $urandom, "rnd_store");
                end
                default: do_op(0, 0, 1, a, $urandom, 2'd3, $urandom,
                               mk_instr(3'($urandom), 5'($urandom)), 0, 0, "rnd_sel3");
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have ports: rst  input  1  asynchronous active-high reset.
REQ-003 SHALL have ports: load_in, store_in, reg_write_in  input  1 each  controls from EX/MEM register.
REQ-004 SHALL have ports: alu_res_in  input  32  effective address or ALU result.
REQ-005 SHALL have ports: opb_data_in  input  32  store data (rs2).
REQ-006 SHALL have ports: mem_reg_in  input  2  writeback select: 0 ALU, 1 load data, 2 next_sel_addr, 3 reserved (treated as 0).
REQ-007 SHALL have ports: next_sel_addr_in, instruction_in  input  32 each  return address; instruction (funct3 = [14:12], rd = [11:7]).
REQ-008 SHALL have ports: dmem_req, dmem_we  output  1 each  memory request; write enable.
REQ-009 SHALL have ports: dmem_addr, dmem_wdata  output  32 each  word address (addr[1:0] = 0); lane-aligned write data.
REQ-010 SHALL have ports: dmem_wmask  output  4  byte-lane enables.
REQ-011 SHALL have ports: dmem_ack  input  1  request completes this cycle; dmem_rdata  input  32  read word, valid with ack.
REQ-012 SHALL have ports: stall_out  output  1  upstream holds EX/MEM contents while high.
REQ-013 SHALL have ports: misaligned_out  output  1  one-cycle registered pulse for a misaligned access.
REQ-014 SHALL have ports: reg_write_out  output  1  MEM/WB write enable; wb_data_out  output  32  writeback value; rd_out  output  5; instruction_out  output  32.

Function
REQ-015 FSM SHALL have states IDLE and WAIT; IDLE -> WAIT when (load_in|store_in) and access aligned; WAIT -> IDLE on dmem_ack; otherwise hold.
REQ-016 Alignment: SH/LH/LHU need addr[0]=0, SW/LW need addr[1:0]=0; byte always aligned; misaligned access SHALL issue no request, no stall, set misaligned_out next cycle, and force reg_write_out=0.
REQ-017 On IDLE->WAIT, address, we, wmask, wdata, funct3, addr[1:0] SHALL be registered; dmem_req SHALL be 1 exactly while in WAIT, with all dmem_* outputs stable.
REQ-018 stall_out SHALL be (IDLE & aligned memop) | (WAIT & ~dmem_ack), combinational.
REQ-019 Store mask: SB 4'b0001<<addr[1:0], data byte replicated to all lanes; SH 4'b0011<<addr[1:0], halfword replicated; SW 4'b1111.
REQ-020 Load extract on ack: select lane by registered addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW full word; funct3 2'b11 encodings (3,6,7) SHALL be treated as LW.
REQ-021 MEM/WB register SHALL capture on every edge where stall_out=0; during stall cycles it SHALL capture a bubble (reg_write_out=0, other fields hold).
REQ-022 Latency: non-memory op 1 cycle; memory op 1 + N cycles where N = WAIT cycles up to and including ack (min 2 total).
REQ-023 Stores SHALL produce reg_write_out=0 regardless of reg_write_in.
REQ-024 dmem_ack while IDLE SHALL be ignored.

Reset
REQ-025 rst SHALL asynchronously force state IDLE, dmem_req=0, dmem_we=0, dmem_wmask=0, dmem_addr/wdata=0, misaligned_out=0, reg_write_out=0, wb_data_out=0, rd_out=0, instruction_out=0.
REQ-026 Reset mid-WAIT SHALL abandon the request; a later ack SHALL be ignored.

Structure
REQ-027 funct3 load/store encodings, mem_reg select values, and FSM state enum SHALL live in a shared package used by decode and this block.
REQ-028 Load extraction/sign-extension SHALL be one combinational sub-module, load_extend.

Verification
REQ-029 ALU op, mem_reg=0, alu_res=0x1234 -> next cycle wb_data_out=0x1234, reg_write_out=1, stall_out never 1.
REQ-030 LB addr 0x103, dmem_rdata=0x80FF_FFFF, ack after 3 WAIT cycles -> stall_out high 4 cycles, dmem_addr=0x100, wb_data_out=0xFFFF_FF80, bubbles before.
REQ-031 SH addr 0x202, opb=0x0000_ABCD -> dmem_wmask=4'b1100, dmem_wdata=0xABCD_ABCD, dmem_we=1, reg_write_out=0.
REQ-032 LW addr 0x101 -> no dmem_req, misaligned_out pulses once, reg_write_out=0, stall_out=0.
REQ-033 rst asserted during WAIT, ack next cycle -> dmem_req drops immediately, state IDLE, no writeback.
REQ-034 JAL-type op, mem_reg=2, next_sel_addr=0x44 -> wb_data_out=0x44.
